// File: rtl/datapath_pkg.sv
// Shared widths, ALU opcode encoding, flag bit positions and ALU helpers
// for the execution datapath.
package datapath_pkg;

    localparam int DATA_W    = 16;
    localparam int RF_DEPTH  = 16;
    localparam int DM_DEPTH  = 256;
    localparam int RF_ADDR_W = 4;
    localparam int DM_ADDR_W = 8;
    localparam int FLAGS_W   = 3;

    // Bit positions inside the {Z,N,C} flags vector
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [2:0] {
        ALU_PASS = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_AND  = 3'b100,
        ALU_XOR  = 3'b101,
        ALU_NOT  = 3'b110,
        ALU_INC  = 3'b111
    } alu_op_e;

    function automatic logic [DATA_W-1:0] alu_result(
        input alu_op_e           op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] r;
        r = '0;
        case (op)
            ALU_PASS: r = a;
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_XOR:  r = a ^ b;
            ALU_NOT:  r = ~a;
            ALU_INC:  r = a + 16'd1;
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Carry-out of the 17-bit sum for add/increment, unsigned borrow for subtract
    function automatic logic alu_carry(
        input alu_op_e           op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] wide;
        logic            c;
        wide = '0;
        c    = 1'b0;
        case (op)
            ALU_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                c    = wide[DATA_W];
            end
            ALU_INC: begin
                wide = {1'b0, a} + 17'd1;
                c    = wide[DATA_W];
            end
            ALU_SUB: c = (a < b);
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/datapath_register_file.sv
// 16x16 register file: two combinational read ports, one synchronous write
// port, every entry cleared by the asynchronous reset.
module register_file
    import datapath_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_en,
    input  logic [RF_ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0]    w_data,
    input  logic [RF_ADDR_W-1:0] ra_addr,
    input  logic [RF_ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0]    ra_data,
    output logic [DATA_W-1:0]    rb_data
);

    logic [DATA_W-1:0] regs [RF_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (w_en) begin
            regs[w_addr] <= w_data;
        end
    end

    // No bypass: a write becomes visible only after its edge
    assign ra_data = regs[ra_addr];
    assign rb_data = regs[rb_addr];

endmodule

// File: rtl/datapath.sv
// Execution datapath: register file, ALU, 256x16 data memory with registered
// read and writeback mux. Optional {Z,N,C} flags register under DATAPATH_FLAGS_EN.
module datapath
    import datapath_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [DM_ADDR_W-1:0] D_Addr,
    input  logic                 D_Wr,
    input  logic                 RF_s,
    input  logic                 RF_W_en,
    input  logic [RF_ADDR_W-1:0] RF_W_Addr,
    input  logic [RF_ADDR_W-1:0] RF_Ra_Addr,
    input  logic [RF_ADDR_W-1:0] RF_Rb_Addr,
    input  logic [2:0]           ALU_s0,
    output logic [DATA_W-1:0]    ALU_A,
    output logic [DATA_W-1:0]    ALU_B,
    output logic [DATA_W-1:0]    ALU_Out,
    output logic [DATA_W-1:0]    W_Data
`ifdef DATAPATH_FLAGS_EN
    ,
    output logic [FLAGS_W-1:0]   Flags
`endif
);

    alu_op_e           alu_op;
    logic [DATA_W-1:0] dm [DM_DEPTH];
    logic [DATA_W-1:0] rd_q;

    assign alu_op = alu_op_e'(ALU_s0);

    register_file u_register_file (
        .clk     (Clk),
        .rst     (Reset),
        .w_en    (RF_W_en),
        .w_addr  (RF_W_Addr),
        .w_data  (W_Data),
        .ra_addr (RF_Ra_Addr),
        .rb_addr (RF_Rb_Addr),
        .ra_data (ALU_A),
        .rb_data (ALU_B)
    );

    always_comb begin
        ALU_Out = alu_result(alu_op, ALU_A, ALU_B);
    end

    // Memory contents are deliberately not reset; stores take port A
    always_ff @(posedge Clk) begin
        if (D_Wr) begin
            dm[D_Addr] <= ALU_A;
        end
    end

    // Non-blocking read alongside the write gives read-before-write on a shared address
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_q <= '0;
        end else begin
            rd_q <= dm[D_Addr];
        end
    end

    assign W_Data = RF_s ? rd_q : ALU_Out;

`ifdef DATAPATH_FLAGS_EN
    logic [FLAGS_W-1:0] flags_q;
    logic [FLAGS_W-1:0] flags_next;

    always_comb begin
        flags_next         = '0;
        flags_next[FLAG_Z] = (ALU_Out == '0);
        flags_next[FLAG_N] = ALU_Out[DATA_W-1];
        flags_next[FLAG_C] = alu_carry(alu_op, ALU_A, ALU_B);
    end

    // Flags track only ALU writebacks; loads and idle cycles leave them alone
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flags_q <= '0;
        end else if (RF_W_en && !RF_s) begin
            flags_q <= flags_next;
        end
    end

    assign Flags = flags_q;
`endif

endmodule

// File: tb/tb_datapath.sv
// Directed, self-checking bench for datapath; flag checks are compiled in
// only when DATAPATH_FLAGS_EN is defined.
module tb_datapath;

    logic        Clk;
    logic        Reset;
    logic [7:0]  D_Addr;
    logic        D_Wr;
    logic        RF_s;
    logic        RF_W_en;
    logic [3:0]  RF_W_Addr;
    logic [3:0]  RF_Ra_Addr;
    logic [3:0]  RF_Rb_Addr;
    logic [2:0]  ALU_s0;
    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic [15:0] ALU_Out;
    logic [15:0] W_Data;
`ifdef DATAPATH_FLAGS_EN
    logic [2:0]  Flags;
`endif

    int vectors;
    int miscompares;

    datapath dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .D_Addr     (D_Addr),
        .D_Wr       (D_Wr),
        .RF_s       (RF_s),
        .RF_W_en    (RF_W_en),
        .RF_W_Addr  (RF_W_Addr),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .ALU_s0     (ALU_s0),
        .ALU_A      (ALU_A),
        .ALU_B      (ALU_B),
        .ALU_Out    (ALU_Out),
        .W_Data     (W_Data)
`ifdef DATAPATH_FLAGS_EN
        ,
        .Flags      (Flags)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic [3:0] wa,
                                 input logic wen, input logic rfs,
                                 input logic [7:0] addr, input logic wr);
        ALU_s0     = op;
        RF_Ra_Addr = ra;
        RF_Rb_Addr = rb;
        RF_W_Addr  = wa;
        RF_W_en    = wen;
        RF_s       = rfs;
        D_Addr     = addr;
        D_Wr       = wr;
        #1;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        Reset       = 1'b1;
        applyStimulus(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 8'h00, 1'b0);
        tick();
        Reset = 1'b0;
        #1;

        checkOutput("reset_alu_a", ALU_A, 16'h0000);
        checkOutput("reset_alu_b", ALU_B, 16'h0000);
        checkOutput("reset_alu_out", ALU_Out, 16'h0000);
        checkOutput("reset_w_data", W_Data, 16'h0000);
`ifdef DATAPATH_FLAGS_EN
        checkOutput("reset_flags", {13'd0, Flags}, 16'h0000);
`endif

        // R1 = R0 + 1
        tick();
        applyStimulus(3'b111, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("inc_r0_out", ALU_Out, 16'h0001);
        tick();

        // R2 = R1 + 1
        applyStimulus(3'b111, 4'd1, 4'd0, 4'd2, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("r1_value", ALU_A, 16'h0001);
        checkOutput("inc_r1_wdata", W_Data, 16'h0002);
        tick();

        // R3 = R1 + R2
        applyStimulus(3'b001, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("r2_value", ALU_B, 16'h0002);
        checkOutput("add_out", ALU_Out, 16'h0003);
`ifdef DATAPATH_FLAGS_EN
        checkOutput("flags_after_inc", {13'd0, Flags}, 16'h0000);
`endif
        tick();

        // R4 = R1 - R2 (borrow)
        applyStimulus(3'b010, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("sub_out", ALU_Out, 16'hFFFF);
`ifdef DATAPATH_FLAGS_EN
        checkOutput("flags_after_add", {13'd0, Flags}, 16'h0000);
`endif
        tick();

        // R5 = R4 + 1 wraps to zero
        applyStimulus(3'b111, 4'd4, 4'd3, 4'd5, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("r4_value", ALU_A, 16'hFFFF);
        checkOutput("r3_value", ALU_B, 16'h0003);
        checkOutput("inc_wrap_out", ALU_Out, 16'h0000);
`ifdef DATAPATH_FLAGS_EN
        checkOutput("flags_after_sub", {13'd0, Flags}, 16'h0003);
`endif
        tick();

        // Store R3 to DM[BC]
        applyStimulus(3'b000, 4'd3, 4'd5, 4'd0, 1'b0, 1'b0, 8'hBC, 1'b1);
        checkOutput("store_src", ALU_A, 16'h0003);
        checkOutput("r5_value", ALU_B, 16'h0000);
`ifdef DATAPATH_FLAGS_EN
        checkOutput("flags_after_wrap", {13'd0, Flags}, 16'h0005);
`endif
        tick();

        // Load cycle 1 then cycle 2 into R6
        applyStimulus(3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 8'hBC, 1'b0);
        tick();
        applyStimulus(3'b000, 4'd0, 4'd0, 4'd6, 1'b1, 1'b1, 8'hBC, 1'b0);
        checkOutput("load_wdata", W_Data, 16'h0003);
        tick();

        // Read R6 while storing R2 to BC and reading BC on the same edge
        applyStimulus(3'b000, 4'd2, 4'd6, 4'd0, 1'b0, 1'b1, 8'hBC, 1'b1);
        checkOutput("r6_loaded", ALU_B, 16'h0003);
`ifdef DATAPATH_FLAGS_EN
        checkOutput("flags_hold_load", {13'd0, Flags}, 16'h0005);
`endif
        tick();
        checkOutput("rbw_old_data", W_Data, 16'h0003);
        applyStimulus(3'b000, 4'd2, 4'd6, 4'd0, 1'b0, 1'b1, 8'hBC, 1'b0);
        tick();
        checkOutput("rbw_new_data", W_Data, 16'h0002);

        // ALU op sweep with A=R3=3, B=R4=FFFF
        applyStimulus(3'b000, 4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("op_pass", ALU_Out, 16'h0003);
        applyStimulus(3'b001, 4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("op_add", ALU_Out, 16'h0002);
        applyStimulus(3'b010, 4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("op_sub", ALU_Out, 16'h0004);
        applyStimulus(3'b011, 4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("op_or", ALU_Out, 16'hFFFF);
        applyStimulus(3'b100, 4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("op_and", ALU_Out, 16'h0003);
        applyStimulus(3'b101, 4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("op_xor", ALU_Out, 16'hFFFC);
        applyStimulus(3'b110, 4'd3, 4'd4, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("op_not", ALU_Out, 16'hFFFC);
        checkOutput("wdata_alu_sel", W_Data, 16'hFFFC);

        // Same-cycle write/read of R1: old value until after the edge
        applyStimulus(3'b111, 4'd1, 4'd0, 4'd1, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("r1_before_edge", ALU_A, 16'h0001);
        tick();
        checkOutput("r1_after_edge", ALU_A, 16'h0002);
        applyStimulus(3'b000, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("r1_stable", ALU_A, 16'h0002);
`ifdef DATAPATH_FLAGS_EN
        checkOutput("flags_after_inc_r1", {13'd0, Flags}, 16'h0000);
`endif

        // Load cycle 1, then reset before cycle 2
        applyStimulus(3'b000, 4'd6, 4'd1, 4'd0, 1'b0, 1'b1, 8'hBC, 1'b0);
        tick();
        checkOutput("load_c1_rdq", W_Data, 16'h0002);
        Reset = 1'b1;
        #1;
        checkOutput("midload_rdq", W_Data, 16'h0000);
        checkOutput("midload_r6", ALU_A, 16'h0000);
        checkOutput("midload_r1", ALU_B, 16'h0000);
`ifdef DATAPATH_FLAGS_EN
        checkOutput("midload_flags", {13'd0, Flags}, 16'h0000);
`endif
        tick();
        Reset = 1'b0;
        applyStimulus(3'b000, 4'd3, 4'd4, 4'd0, 1'b0, 1'b1, 8'hBC, 1'b0);
        checkOutput("post_reset_r3", ALU_A, 16'h0000);
        checkOutput("post_reset_r4", ALU_B, 16'h0000);
        tick();
        checkOutput("dm_retained", W_Data, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/datapath.md
# datapath

Execution datapath that sits directly downstream of the control unit. It consumes the decoded control word each cycle and carries out the instruction:
- RF_Ra_Addr, RF_Rb_Addr and RF_W_Addr select registers.
- RF_W_en and RF_s control register-file writeback.
- ALU_s0 selects the ALU operation.
- D_Addr and D_Wr control data-memory access.

It holds a 16×16 register file, a 16-bit ALU and a 256×16 data memory with registered read, and writes back either the ALU result or the memory data.

## Interface
- DATA_W, 16, datapath word width
- RF_DEPTH, 16, register count (address width 4)
- DM_DEPTH, 256, data-memory words (address width 8)
- Clk  input  1  single clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high; clears register file, memory read register, flags
- D_Addr  input  8  data-memory address
- D_Wr  input  1  data-memory write enable
- RF_s  input  1  writeback select: 1 = memory read data, 0 = ALU result
- RF_W_en  input  1  register-file write enable
- RF_W_Addr  input  4  write register
- RF_Ra_Addr  input  4  read port A register
- RF_Rb_Addr  input  4  read port B register
- ALU_s0  input  3  ALU operation
- ALU_A  output  16  RF[RF_Ra_Addr], combinational
- ALU_B  output  16  RF[RF_Rb_Addr], combinational
- ALU_Out  output  16  ALU result, combinational
- W_Data  output  16  writeback mux output, combinational
- Flags  output  3  {Z,N,C}, registered; present only with DATAPATH_FLAGS_EN

## Operation
- Register file: two combinational read ports and one synchronous write port. Write RF[RF_W_Addr] <= W_Data on a Clk edge when RF_W_en=1. R0 is an ordinary register.
- ALU ops (ALU_s0):
  - 000 pass A
  - 001 A+B
  - 010 A−B
  - 011 A|B
  - 100 A&B
  - 101 A^B
  - 110 ~A
  - 111 A+1
- Arithmetic wraps modulo 2^16; the carry-out is computed on a 17-bit sum.
- Data memory write: on the edge where D_Wr=1, DM[D_Addr] <= ALU_A. Store therefore uses port A as its source.
- Data memory read: on every edge, rd_q <= DM[D_Addr].
- W_Data = RF_s ? rd_q : ALU_Out.
- Load takes two cycles and matches the controller's two load states:
  - Cycle 1 (D_Addr valid, RF_s=1, RF_W_en=0) captures rd_q.
  - Cycle 2 (RF_s=1, RF_W_en=1) writes rd_q to the register file.
- No internal FSM. All sequencing is owned by the controller; the datapath reacts purely to the control word on each cycle.

## Timing
- Reset (asynchronous assert, synchronous release): all RF entries = 0, rd_q = 0, Flags = 0. Consequently ALU_A = ALU_B = 0, ALU_Out = op(0,0), and W_Data = 0 when RF_s=1.
- Data memory contents are not reset; they are undefined until written. Reset asserted mid-load discards rd_q.
- Register read latency is 0 cycles. Register write is visible on ALU_A/ALU_B from the cycle after the write edge. There is no forwarding: a same-cycle read returns the old value.
- Memory read latency is 1 cycle. Same-edge read and write to the same address: rd_q gets the old data (read-before-write).
- D_Wr and RF_W_en may be asserted together. Both writes occur, and the memory write uses the pre-edge value of ALU_A.
- Address out of range is impossible, since widths are exact.

## Configuration
- DATAPATH_FLAGS_EN defined: Flags register is instantiated and updated on edges where RF_W_en=1 and RF_s=0.
  - Z = (ALU_Out==0)
  - N = ALU_Out[15]
  - C = carry-out for 001/111, borrow (A<B unsigned) for 010, 0 otherwise
  - Otherwise Flags hold their value.
- DATAPATH_FLAGS_EN undefined: the Flags port and its logic are absent.

## Structure
- Package datapath_pkg holds:
  - DATA_W, RF_ADDR_W = 4, DM_ADDR_W = 8
  - typedef enum logic [2:0] alu_op_e (ALU_PASS, ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_NOT, ALU_INC)
  - flag index constants
- Sub-module register_file: 2 read / 1 write ports with async reset. The ALU, memory and writeback mux stay in datapath.

## Test plan
- Reset=1 for 1 cycle, then ALU_s0=000, Ra=Rb=any → ALU_A=ALU_B=0, ALU_Out=0; with flags, Flags=000.
- ALU_s0=111, Ra=0, W=1, W_en=1, then same with Ra=1, W=2 → R1=1, R2=2. Next, ALU_s0=001, Ra=1, Rb=2, W=3 → R3=3, Flags=000.
- ALU_s0=010, Ra=1, Rb=2, W=4 → R4=16'hFFFF, Flags=011 (N, C/borrow). Then ALU_s0=111, Ra=4, W=5 → R5=0, Flags=101.
- Store: D_Addr=8'hBC, D_Wr=1, Ra=3 → DM[BC]=3. Load cycle 1: D_Addr=BC, RF_s=1. Cycle 2: RF_s=1, W_en=1, W=6 → R6=3 one cycle after the address is presented.
- Same-edge D_Wr to BC with value 2 while reading BC → rd_q=3 (old), DM[BC]=2 on the next read. Same-cycle RF write/read of R1 → ALU_A shows the old value until after the edge.
- Assert Reset between load cycle 1 and cycle 2 → rd_q=0 and all registers 0, while DM[BC] retains its value.
